// File: rtl/fact_pkg.sv
// Shared definitions for the factorial accelerator: register offsets,
// FSM state encoding and default operand limits.
package fact_pkg;

  localparam logic [1:0] FACT_N      = 2'd0;
  localparam logic [1:0] FACT_GO     = 2'd1;
  localparam logic [1:0] FACT_STATUS = 2'd2;
  localparam logic [1:0] FACT_RESULT = 2'd3;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam int FACT_N_WIDTH = 4;
  localparam int FACT_MAX_N   = 12;

endpackage

// File: rtl/fact_datapath.sv
// Iterative factorial datapath: a private down-counter and a running product
// fed by a 32 x N_WIDTH multiplier truncated to 32 bits.
module fact_datapath
  import fact_pkg::*;
#(
  parameter int N_WIDTH = FACT_N_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [N_WIDTH-1:0] n,
  output logic [31:0]        prod,
  output logic               cnt_le1
);

  logic [N_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]        prod_q, prod_d;

  // Load seeds the counter with n and the product with 1; each step folds
  // the current count into the product and counts down.
  always_comb begin
    cnt_d  = cnt_q;
    prod_d = prod_q;
    if (load) begin
      cnt_d  = n;
      prod_d = 32'd1;
    end else if (step) begin
      prod_d = prod_q * {{(32-N_WIDTH){1'b0}}, cnt_q};
      cnt_d  = cnt_q - N_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      prod_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      prod_q <= prod_d;
    end
  end

  assign prod    = prod_q;
  assign cnt_le1 = (cnt_q <= N_WIDTH'(1));

endmodule

// File: rtl/fact_accel.sv
// Memory-mapped factorial accelerator: N/GO/STATUS/RESULT register file,
// a two-state control FSM and a combinational read mux.
module fact_accel
  import fact_pkg::*;
#(
  parameter int N_WIDTH = FACT_N_WIDTH,
  parameter int MAX_N   = FACT_MAX_N
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        WE,
  input  logic [1:0]  A,
  input  logic [31:0] WD,
  output logic [31:0] RD
);

  logic [0:0]         state_q, state_d;
  logic [N_WIDTH-1:0] n_q, n_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [31:0]        result_q, result_d;

  logic        goAccept;
  logic        nTooBig;
  logic        dpLoad;
  logic        dpStep;
  logic [31:0] dpProd;
  logic        dpCntLe1;
  logic        busy;
  logic        unused_wd;

  assign busy      = (state_q == BUSY);
  assign goAccept  = WE && (A == FACT_GO) && WD[0] && (state_q == IDLE);
  assign nTooBig   = ({{(32-N_WIDTH){1'b0}}, n_q} > 32'(MAX_N));
  assign dpLoad    = goAccept && !nTooBig;
  assign dpStep    = busy && !dpCntLe1;
  assign unused_wd = &{1'b0, WD[31:N_WIDTH]};

  fact_datapath #(
    .N_WIDTH (N_WIDTH)
  ) u_datapath (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (dpLoad),
    .step    (dpStep),
    .n       (n_q),
    .prod    (dpProd),
    .cnt_le1 (dpCntLe1)
  );

  // N is writable at any time since the datapath keeps its own count;
  // done/err stay set until the next accepted Go.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    done_d   = done_q;
    err_d    = err_q;
    result_d = result_q;
    if (WE && (A == FACT_N)) begin
      n_d = WD[N_WIDTH-1:0];
    end
    case (state_q)
      IDLE: begin
        if (goAccept) begin
          result_d = '0;
          if (nTooBig) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            done_d  = 1'b0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (dpCntLe1) begin
          result_d = dpProd;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      n_q      <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    RD = '0;
    case (A)
      FACT_N:      RD = {{(32-N_WIDTH){1'b0}}, n_q};
      FACT_GO:     RD = {31'b0, busy};
      FACT_STATUS: RD = {30'b0, err_q, done_q};
      FACT_RESULT: RD = result_q;
      default:     RD = '0;
    endcase
  end

endmodule

// File: tb/tb_fact_accel.sv
// Directed scoreboard bench for fact_accel: each bus cycle may queue an
// expected read word that a separate monitor compares at the falling edge.
module tb_fact_accel;

  localparam logic [1:0] OFF_N      = 2'd0;
  localparam logic [1:0] OFF_GO     = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_RESULT = 2'd3;

  logic        clk;
  logic        rst_n;
  logic        WE;
  logic [1:0]  A;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        rdReq;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } expEntry_t;

  expEntry_t expQ[$];
  int checks = 0;
  int errors = 0;

  fact_accel dut (
    .clk   (clk),
    .rst_n (rst_n),
    .WE    (WE),
    .A     (A),
    .WD    (WD),
    .RD    (RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h (%0d), expected 0x%08h (%0d)",
               name, actual, actual, expected, expected);
    end
  endtask

  // Monitor: whenever a read is presented, pop the oldest expectation.
  always @(negedge clk) begin
    if (rdReq) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard: read presented with no expectation queued");
      end else begin
        expEntry_t e;
        e = expQ.pop_front();
        checkOutput(e.name, RD, e.exp);
      end
    end
  end

  // One bus cycle; starts and ends 1 time unit after a rising edge.
  task automatic applyStimulus(input logic we, input logic [1:0] addr,
                               input logic [31:0] wdata, input logic chk,
                               input logic [31:0] expVal, input string name);
    expEntry_t e;
    WE = we;
    A  = addr;
    WD = wdata;
    if (chk) begin
      e.name = name;
      e.exp  = expVal;
      expQ.push_back(e);
      rdReq = 1'b1;
    end
    @(negedge clk);
    #1 rdReq = 1'b0;
    @(posedge clk);
    #1 WE = 1'b0;
  endtask

  task automatic rd(input logic [1:0] addr, input logic [31:0] expVal,
                    input string name);
    applyStimulus(1'b0, addr, 32'd0, 1'b1, expVal, name);
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, addr, data, 1'b0, 32'd0, "");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    WE    = 1'b0;
    A     = 2'd0;
    WD    = 32'd0;
    rdReq = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    rd(OFF_N,      32'd0, "reset_N");
    rd(OFF_GO,     32'd0, "reset_GO");
    rd(OFF_STATUS, 32'd0, "reset_STATUS");
    rd(OFF_RESULT, 32'd0, "reset_RESULT");

    // 5!: busy for cycles after edges k..k+4, done after k+5
    wr(OFF_N, 32'd5);
    rd(OFF_N, 32'd5, "n5_readback");
    wr(OFF_GO, 32'd1);
    for (int i = 0; i < 5; i++) rd(OFF_GO, 32'd1, "f5_busy");
    rd(OFF_STATUS, 32'd1, "f5_status");
    rd(OFF_RESULT, 32'd120, "f5_result");
    rd(OFF_GO, 32'd0, "f5_idle");

    // 0!: completes after k+1; a Go in the following cycle is accepted
    wr(OFF_N, 32'd0);
    wr(OFF_GO, 32'd1);
    rd(OFF_STATUS, 32'd0, "f0_running");
    applyStimulus(1'b1, OFF_GO, 32'd1, 1'b1, 32'd0, "f0_b2b_not_busy");
    rd(OFF_STATUS, 32'd0, "f0_b2b_cleared");
    rd(OFF_STATUS, 32'd1, "f0_b2b_done");
    rd(OFF_RESULT, 32'd1, "f0_result");

    // 12!: the largest operand, done after k+12
    wr(OFF_N, 32'd12);
    wr(OFF_GO, 32'd1);
    rd(OFF_GO, 32'd1, "f12_busy");
    idle(10);
    rd(OFF_STATUS, 32'd0, "f12_not_yet");
    rd(OFF_STATUS, 32'd1, "f12_status");
    rd(OFF_RESULT, 32'd479001600, "f12_result");

    // 13: error flags set at edge k, busy never rises
    wr(OFF_N, 32'd13);
    wr(OFF_GO, 32'd1);
    rd(OFF_STATUS, 32'd3, "f13_status");
    rd(OFF_RESULT, 32'd0, "f13_result");
    rd(OFF_GO, 32'd0, "f13_never_busy");
    wr(OFF_GO, 32'd0);
    rd(OFF_STATUS, 32'd3, "go0_no_effect");
    wr(OFF_STATUS, 32'd0);
    rd(OFF_STATUS, 32'd3, "status_write_ignored");
    wr(OFF_RESULT, 32'hDEADBEEF);
    rd(OFF_RESULT, 32'd0, "result_write_ignored");

    // 3!: err cleared by the next accepted Go
    wr(OFF_N, 32'd3);
    wr(OFF_GO, 32'd1);
    rd(OFF_STATUS, 32'd0, "f3_err_cleared");
    rd(OFF_GO, 32'd1, "f3_busy1");
    rd(OFF_GO, 32'd1, "f3_busy2");
    rd(OFF_STATUS, 32'd1, "f3_status");
    rd(OFF_RESULT, 32'd6, "f3_result");

    // 7!: N and Go written mid-run must not disturb it
    wr(OFF_N, 32'd7);
    wr(OFF_GO, 32'd1);
    rd(OFF_RESULT, 32'd0, "f7_result_cleared");
    rd(OFF_GO, 32'd1, "f7_busy");
    wr(OFF_N, 32'd2);
    wr(OFF_GO, 32'd1);
    rd(OFF_N, 32'd2, "f7_n_written");
    rd(OFF_GO, 32'd1, "f7_busy_k5");
    rd(OFF_GO, 32'd1, "f7_busy_k6");
    rd(OFF_STATUS, 32'd1, "f7_status");
    rd(OFF_RESULT, 32'd5040, "f7_result");

    // 2! using the N written during the previous run
    wr(OFF_GO, 32'd1);
    rd(OFF_STATUS, 32'd0, "f2_running0");
    rd(OFF_STATUS, 32'd0, "f2_running1");
    rd(OFF_STATUS, 32'd1, "f2_status");
    rd(OFF_RESULT, 32'd2, "f2_result");

    // Reset in the middle of a 6! run
    wr(OFF_N, 32'd6);
    wr(OFF_GO, 32'd1);
    rd(OFF_GO, 32'd1, "f6_busy");
    rd(OFF_RESULT, 32'd0, "f6_result_running");
    rst_n = 1'b0;
    rd(OFF_N,      32'd0, "midrst_N");
    rd(OFF_GO,     32'd0, "midrst_GO");
    rd(OFF_STATUS, 32'd0, "midrst_STATUS");
    rd(OFF_RESULT, 32'd0, "midrst_RESULT");
    rst_n = 1'b1;
    rd(OFF_STATUS, 32'd0, "postrst_STATUS");

    // 4! after reset release
    wr(OFF_N, 32'd4);
    wr(OFF_GO, 32'd1);
    rd(OFF_GO, 32'd1, "f4_busy");
    idle(2);
    rd(OFF_STATUS, 32'd0, "f4_not_yet");
    rd(OFF_STATUS, 32'd1, "f4_status");
    rd(OFF_RESULT, 32'd24, "f4_result");

    idle(2);
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d expectations left, expected 0",
               expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fact_accel.md
# fact_accel

Memory-mapped factorial accelerator that responds to the system bus in the 0x800–0x8FF window. It consumes the write strobe from the address decoder (its WE1 output) and drives a read word that the decoder's RdSel = 3'b010 path selects. Software writes n and a Go bit, polls status, and reads n! as a 32-bit result. An iterative multiply/decrement FSM computes the result.

## Interface
Parameters:
- N_WIDTH, 4: width of the stored operand n.
- MAX_N, 12: largest n whose factorial fits in 32 bits; a larger n raises an error.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- WE  in  1  write strobe, driven by the address decoder's WE1.
- A  in  2  word offset within the block, bus address bits [3:2].
- WD  in  32  write data.
- RD  out  32  read data, combinational from A and the internal registers.

## Operation
Register map (offset : access):
- 0x0 N : R/W. Bits [N_WIDTH-1:0]; reads zero-extended.
- 0x4 GO : W/R. Writing WD[0]=1 requests a start. Reads {31'b0, busy}.
- 0x8 STATUS : R. Reads {30'b0, err, done}. Writes are ignored.
- 0xC RESULT : R. Writes are ignored.

FSM states and transitions:
- IDLE → BUSY on an accepted Go with n ≤ MAX_N.
  - Load cnt = n and prod = 1.
  - Clear done and err, and set result = 0.
- IDLE → IDLE on an accepted Go with n > MAX_N.
  - Set err = 1 and done = 1; result = 0.
- BUSY, cnt > 1: prod ← prod × cnt (low 32 bits), cnt ← cnt − 1.
- BUSY, cnt ≤ 1: result ← prod, done ← 1, return to IDLE.

Acceptance and write rules:
- A Go write is accepted only in IDLE. A Go write while BUSY is ignored and the running operation is unaffected.
- A write to N is accepted in any state. cnt is a private copy, so a write to N during BUSY affects only the next Go.
- WD[0]=0 written to GO has no effect.
- done and err are sticky. They are cleared only by the next accepted Go or by reset.

Arithmetic:
- The multiplier is 32×N_WIDTH. The product is truncated to 32 bits.
- Truncation never occurs for n ≤ MAX_N.

## Timing
- Reset values: N=0, state=IDLE, busy=0, done=0, err=0, result=0, so RD=0 at every offset.
- Go accepted at edge k → busy=1 after edge k.
- done=1 and busy=0 after edge k+max(n,1).
  - 0! and 1! complete after edge k+1.
  - 5! completes after edge k+5.
- Error path: err=done=1 after edge k itself; busy is never asserted.
- RESULT reads 0 from edge k until completion, then holds n!.
- RD has no latency: it changes in the same cycle as A or the registers.
- Reset asserted mid-operation immediately forces every register to its reset value. No partial result survives.
- Back-to-back: a Go issued in the cycle after done rises is accepted normally.

## Structure
- Shared package fact_pkg holds:
  - offset constants FACT_N=2'd0, FACT_GO=2'd1, FACT_STATUS=2'd2, FACT_RESULT=2'd3;
  - the state encoding IDLE / BUSY;
  - the default MAX_N.
- One sub-module, fact_datapath, contains cnt, prod and the multiplier. Its inputs are load, step and the n value. Its outputs are prod and cnt_le1.
- The top level holds the register file, the FSM and the read mux.

## Test plan
- After reset, read all four offsets → each returns 0.
- Write N=5, then Go=1 at edge k → busy=1 from k to k+4; STATUS=2'b01 and RESULT=120 after edge k+5.
- N=0, Go → RESULT=1 and done=1 after edge k+1. N=12, Go → RESULT=479001600 after edge k+12.
- N=13, Go → STATUS=2'b11 after edge k, RESULT=0, busy never 1. Then N=3 and Go → err cleared, RESULT=6.
- During an N=7 run, write N=2 and Go=1 at k+3 → both ignored for this run; RESULT=5040 after k+7. A following Go computes 2! = 2.
- Assert rst_n=0 at k+2 of an N=6 run → all reads return 0 immediately. After release, a new Go with N=4 yields 24.
